coriolis_stream_join: RTL

Upstream input stage for the Coriolis kernel top. It accepts four independently handshaked 32-bit float lanes (u, v, x, y), buffers each lane in a small FIFO, and presents them as one lockstep tuple. That tuple uses the single ivalid/iready pair the kernel top consumes. It also counts tuples per frame and flags the last tuple of each frame.

---
 rtl/coriolis_stream_join.sv | 137 +++++++++++++
 1 files changed

// File: rtl/coriolis_stream_join.sv
// coriolis_stream_join
//   Joins four independently handshaked lanes (u, v, x, y) into one lockstep
//   tuple for the Coriolis kernel top. Each lane is buffered in its own
//   DEPTH-entry circular FIFO. A tuple is offered once every lane holds at
//   least one entry, and all lanes pop together. The block also counts tuples
//   per frame and flags the last tuple of each frame.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   {u,v,x,y}_in / _ivalid       lane data and valid from the producers
//   {u,v,x,y}_iready             registered "lane not full"
//   {u,v,x,y}_stream             joined head tuple; zero while ovalid is low
//   ovalid / oready              tuple handshake toward the kernel top
//   frame_last                   head tuple is element NELEM-1 of its frame
//   tuple_cnt                    index of the head tuple within its frame
module coriolis_stream_join #(
  parameter int unsigned STREAMW = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NELEM   = 1024,
  localparam int unsigned CntW   = (NELEM > 1) ? $clog2(NELEM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STREAMW-1:0] u_in,
  input  logic [STREAMW-1:0] v_in,
  input  logic [STREAMW-1:0] x_in,
  input  logic [STREAMW-1:0] y_in,
  input  logic               u_ivalid,
  input  logic               v_ivalid,
  input  logic               x_ivalid,
  input  logic               y_ivalid,
  output logic               u_iready,
  output logic               v_iready,
  output logic               x_iready,
  output logic               y_iready,
  output logic [STREAMW-1:0] u_stream,
  output logic [STREAMW-1:0] v_stream,
  output logic [STREAMW-1:0] x_stream,
  output logic [STREAMW-1:0] y_stream,
  output logic               ovalid,
  input  logic               oready,
  output logic               frame_last,
  output logic [CntW-1:0]    tuple_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] LaneFull = (PtrW + 1)'(DEPTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(NELEM - 1);

  logic [STREAMW-1:0] w_in   [4];
  logic [STREAMW-1:0] w_head [4];
  logic [3:0]         w_ivalid;
  logic [3:0]         w_iready;
  logic [3:0]         w_nempty;
  logic               w_ovalid;
  logic               w_fire;
  logic [CntW-1:0]    r_tuple_cnt;

  assign w_in[0] = u_in;
  assign w_in[1] = v_in;
  assign w_in[2] = x_in;
  assign w_in[3] = y_in;
  assign w_ivalid = {y_ivalid, x_ivalid, v_ivalid, u_ivalid};

  assign w_ovalid = &w_nempty;
  assign w_fire   = w_ovalid & oready;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [STREAMW-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]    r_wr_ptr;
    logic [PtrW-1:0]    r_rd_ptr;
    logic [PtrW:0]      r_count;
    logic [PtrW:0]      w_count_d;
    logic               r_iready;
    logic               w_push;

    // Push is qualified by last cycle's registered ready, so a lane that is
    // full this cycle cannot accept even if a pop happens in the same cycle.
    assign w_push = w_ivalid[l] & r_iready;

    always_comb begin
      w_count_d = r_count;
      if (w_push && !w_fire) begin
        w_count_d = r_count + 1'b1;
      end else if (!w_push && w_fire) begin
        w_count_d = r_count - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_iready <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count  <= w_count_d;
        r_iready <= (w_count_d != LaneFull);
      end
    end

    // Storage needs no reset: it is only observed through the head while
    // the lane count is non-zero.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_in[l];
    end

    assign w_nempty[l] = (r_count != '0);
    assign w_head[l]   = r_mem[r_rd_ptr];
    assign w_iready[l] = r_iready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tuple_cnt <= '0;
    end else if (w_fire) begin
      r_tuple_cnt <= (r_tuple_cnt == LastIdx) ? '0 : r_tuple_cnt + 1'b1;
    end
  end

  assign u_iready = w_iready[0];
  assign v_iready = w_iready[1];
  assign x_iready = w_iready[2];
  assign y_iready = w_iready[3];

  assign u_stream = w_ovalid ? w_head[0] : '0;
  assign v_stream = w_ovalid ? w_head[1] : '0;
  assign x_stream = w_ovalid ? w_head[2] : '0;
  assign y_stream = w_ovalid ? w_head[3] : '0;

  assign ovalid     = w_ovalid;
  assign tuple_cnt  = r_tuple_cnt;
  assign frame_last = w_ovalid & (r_tuple_cnt == LastIdx);

endmodule
